// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared load/store op-code bit indices and memory-stage FSM states
package core_pkg;
  localparam int LS_W   = 11;
  localparam int LS_LB  = 0;
  localparam int LS_LH  = 1;
  localparam int LS_LW  = 2;
  localparam int LS_LD  = 3;
  localparam int LS_LBU = 4;
  localparam int LS_LHU = 5;
  localparam int LS_LWU = 6;
  localparam int LS_SB  = 7;
  localparam int LS_SH  = 8;
  localparam int LS_SW  = 9;
  localparam int LS_SD  = 10;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  // Anything other than exactly one bit set is a non-memory op.
  function automatic logic is_onehot(input logic [LS_W-1:0] v);
    return (v != '0) && ((v & (v - LS_W'(1))) == '0);
  endfunction
endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the load lane from a doubleword and sign/zero-extends it
module load_align
  import core_pkg::*;
(
  input  logic [63:0]     data_i,
  input  logic [2:0]      offset_i,
  input  logic [LS_W-1:0] info_i,
  output logic [63:0]     data_o
);
  logic [63:0] shifted;

  assign shifted = data_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = shifted;
    if (info_i[LS_LB])       data_o = {{56{shifted[7]}},  shifted[7:0]};
    else if (info_i[LS_LH])  data_o = {{48{shifted[15]}}, shifted[15:0]};
    else if (info_i[LS_LW])  data_o = {{32{shifted[31]}}, shifted[31:0]};
    else if (info_i[LS_LBU]) data_o = {56'd0, shifted[7:0]};
    else if (info_i[LS_LHU]) data_o = {48'd0, shifted[15:0]};
    else if (info_i[LS_LWU]) data_o = {32'd0, shifted[31:0]};
  end
endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory stage: data-bus handshake, store lane packing, load writeback
module mem_access
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [LS_W-1:0] regM_i_load_store_info,
  input  logic [63:0]     regM_i_alu_result,
  input  logic [63:0]     regM_i_regdata2,
  input  logic [4:0]      regM_i_rd,
  input  logic            regM_i_reg_wen,
  input  logic            regM_i_commit,
  input  logic [63:0]     regM_i_commit_pre_pc,
  input  logic [31:0]     regM_i_commit_instr,
  input  logic [63:0]     regM_i_commit_pc,
  output logic            dmem_o_req,
  output logic            dmem_o_we,
  output logic [63:0]     dmem_o_addr,
  output logic [63:0]     dmem_o_wdata,
  output logic [7:0]      dmem_o_wstrb,
  input  logic            dmem_i_ack,
  input  logic [63:0]     dmem_i_rdata,
  output logic            memory_o_stall,
  output logic [63:0]     memory_o_wb_data,
  output logic [4:0]      memory_o_rd,
  output logic            memory_o_reg_wen,
  output logic            memory_o_misalign,
  output logic            memory_o_commit,
  output logic [63:0]     memory_o_commit_pre_pc,
  output logic [31:0]     memory_o_commit_instr,
  output logic [63:0]     memory_o_commit_pc
);
  logic [LS_W-1:0] info;
  logic [63:0]     addr;
  logic [63:0]     rs2;
  logic            onehot, is_load, is_store, sz_h, sz_w, sz_d;
  logic            misalign, mem_op;
  logic [63:0]     load_data;
  mem_state_e      state_q;
  logic [63:0]     rdata_q;

  assign info = regM_i_load_store_info;
  assign addr = regM_i_alu_result;
  assign rs2  = regM_i_regdata2;

  assign onehot   = is_onehot(info);
  assign is_load  = onehot & (|info[LS_LWU:LS_LB]);
  assign is_store = onehot & (|info[LS_SD:LS_SB]);
  assign sz_h     = onehot & (info[LS_LH] | info[LS_LHU] | info[LS_SH]);
  assign sz_w     = onehot & (info[LS_LW] | info[LS_LWU] | info[LS_SW]);
  assign sz_d     = onehot & (info[LS_LD] | info[LS_SD]);
  assign misalign = (sz_h & addr[0]) | (sz_w & (|addr[1:0])) | (sz_d & (|addr[2:0]));
  assign mem_op   = onehot & ~misalign;

  // An ack coinciding with the IDLE request is accepted straight into DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEM_IDLE;
      rdata_q <= '0;
    end else begin
      case (state_q)
        MEM_IDLE: begin
          if (mem_op) begin
            if (dmem_i_ack) begin
              state_q <= MEM_DONE;
              rdata_q <= dmem_i_rdata;
            end else begin
              state_q <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (dmem_i_ack) begin
            state_q <= MEM_DONE;
            rdata_q <= dmem_i_rdata;
          end
        end
        MEM_DONE: state_q <= MEM_IDLE;
        default:  state_q <= MEM_IDLE;
      endcase
    end
  end

  assign dmem_o_req     = ((state_q == MEM_IDLE) & mem_op) | (state_q == MEM_WAIT);
  assign dmem_o_we      = is_store & ~misalign;
  assign dmem_o_addr    = {addr[63:3], 3'b000};
  assign memory_o_stall = mem_op & (state_q != MEM_DONE);

  always_comb begin
    dmem_o_wdata = '0;
    dmem_o_wstrb = '0;
    if (is_store & ~misalign) begin
      if (info[LS_SB]) begin
        dmem_o_wdata = {8{rs2[7:0]}};
        dmem_o_wstrb = 8'h01 << addr[2:0];
      end else if (info[LS_SH]) begin
        dmem_o_wdata = {4{rs2[15:0]}};
        dmem_o_wstrb = 8'h03 << addr[2:0];
      end else if (info[LS_SW]) begin
        dmem_o_wdata = {2{rs2[31:0]}};
        dmem_o_wstrb = 8'h0F << addr[2:0];
      end else begin
        dmem_o_wdata = rs2;
        dmem_o_wstrb = 8'hFF;
      end
    end
  end

  load_align u_load_align (
    .data_i   (rdata_q),
    .offset_i (addr[2:0]),
    .info_i   (info),
    .data_o   (load_data)
  );

  // Stalled cycles must not retire, or the instruction would commit twice.
  assign memory_o_wb_data       = (is_load & ~misalign) ? load_data : addr;
  assign memory_o_rd            = regM_i_rd;
  assign memory_o_reg_wen       = regM_i_reg_wen & ~misalign & ~memory_o_stall;
  assign memory_o_misalign      = misalign;
  assign memory_o_commit        = regM_i_commit & ~memory_o_stall;
  assign memory_o_commit_pre_pc = regM_i_commit_pre_pc;
  assign memory_o_commit_instr  = regM_i_commit_instr;
  assign memory_o_commit_pc     = regM_i_commit_pc;
endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - vector table, directed corner sequences and randomized ops against a lane model
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] info_i;
  logic [63:0] alu_i, rs2_i, pre_pc_i, pc_i, rdata_i;
  logic [4:0]  rd_i;
  logic        reg_wen_i, commit_i, ack_i;
  logic [31:0] instr_i;
  logic        req_o, we_o, stall_o, reg_wen_o, mis_o, commit_o;
  logic [63:0] addr_o, wdata_o, wb_o, pre_pc_o, pc_o;
  logic [7:0]  wstrb_o;
  logic [4:0]  rd_o;
  logic [31:0] instr_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst),
    .regM_i_load_store_info(info_i), .regM_i_alu_result(alu_i), .regM_i_regdata2(rs2_i),
    .regM_i_rd(rd_i), .regM_i_reg_wen(reg_wen_i), .regM_i_commit(commit_i),
    .regM_i_commit_pre_pc(pre_pc_i), .regM_i_commit_instr(instr_i), .regM_i_commit_pc(pc_i),
    .dmem_o_req(req_o), .dmem_o_we(we_o), .dmem_o_addr(addr_o), .dmem_o_wdata(wdata_o),
    .dmem_o_wstrb(wstrb_o), .dmem_i_ack(ack_i), .dmem_i_rdata(rdata_i),
    .memory_o_stall(stall_o), .memory_o_wb_data(wb_o), .memory_o_rd(rd_o),
    .memory_o_reg_wen(reg_wen_o), .memory_o_misalign(mis_o), .memory_o_commit(commit_o),
    .memory_o_commit_pre_pc(pre_pc_o), .memory_o_commit_instr(instr_o), .memory_o_commit_pc(pc_o)
  );

  typedef struct {
    logic [10:0] info;
    logic [63:0] addr;
    logic [63:0] rs2;
    logic [63:0] rdata;
    int          delay;
    logic [63:0] exp_wb;
    logic [7:0]  exp_wstrb;
    logic [63:0] exp_wdata;
    logic        exp_mis;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int size_of(input logic [10:0] info);
    if (info[0] || info[4] || info[7]) return 1;
    if (info[1] || info[5] || info[8]) return 2;
    if (info[2] || info[6] || info[9]) return 4;
    return 8;
  endfunction

  // Reference built from byte counts and arithmetic on the address.
  function automatic vec_t model(input logic [10:0] info, input logic [63:0] addr,
                                 input logic [63:0] rs2, input logic [63:0] rdata, input int delay);
    vec_t v;
    int n, k, s;
    bit oh, ld, st;
    logic [63:0] mask, val;
    v.info = info; v.addr = addr; v.rs2 = rs2; v.rdata = rdata; v.delay = delay;
    n  = size_of(info);
    k  = int'(addr % 8);
    oh = ($countones(info) == 1);
    ld = oh && (info[6:0] != 0);
    st = oh && (info[10:7] != 0);
    v.exp_mis = oh && ((addr % n) != 0);
    s = ((1 << n) - 1) << k;
    v.exp_wstrb = st ? s[7:0] : 8'h00;
    v.exp_wdata = '0;
    for (int b = 0; b < 8; b++) v.exp_wdata[8*b +: 8] = rs2[8*(b % n) +: 8];
    mask = (n == 8) ? {64{1'b1}} : ((64'd1 << (8*n)) - 64'd1);
    val  = (rdata >> (8*k)) & mask;
    if ((info[0] || info[1] || info[2]) && val[8*n-1]) val = val | ~mask;
    v.exp_wb = (ld && !v.exp_mis) ? val : addr;
    return v;
  endfunction

  task automatic run_op(input vec_t v, input string tag);
    bit   memop, st;
    int   ncyc;
    logic rw_in;
    memop = ($countones(v.info) == 1) && !v.exp_mis;
    st    = ($countones(v.info) == 1) && (v.info[10:7] != 0);
    rw_in = (v.info[10:7] == 0);
    ncyc  = memop ? v.delay + 2 : 1;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        rst = 1'b0; info_i = v.info; alu_i = v.addr; rs2_i = v.rs2;
        rd_i = 5'($urandom); reg_wen_i = rw_in; commit_i = 1'b1;
        pre_pc_i = {$urandom, $urandom}; pc_i = {$urandom, $urandom}; instr_i = $urandom;
      end
      ack_i   = memop && (c == v.delay);
      rdata_i = (c == v.delay) ? v.rdata : {$urandom, $urandom};
      @(negedge clk);
      if (memop && c <= v.delay) begin
        chk({tag, ".req"}, 64'(req_o), 64'd1);
        chk({tag, ".stall"}, 64'(stall_o), 64'd1);
        chk({tag, ".commit_hold"}, 64'(commit_o), 64'd0);
        chk({tag, ".wen_hold"}, 64'(reg_wen_o), 64'd0);
        chk({tag, ".addr"}, addr_o, v.addr & ~64'd7);
        chk({tag, ".we"}, 64'(we_o), 64'(st));
        chk({tag, ".wstrb"}, 64'(wstrb_o), 64'(v.exp_wstrb));
        if (st) chk({tag, ".wdata"}, wdata_o, v.exp_wdata);
      end else begin
        chk({tag, ".req_end"}, 64'(req_o), 64'd0);
        chk({tag, ".stall_end"}, 64'(stall_o), 64'd0);
        chk({tag, ".wb"}, wb_o, v.exp_wb);
        chk({tag, ".mis"}, 64'(mis_o), 64'(v.exp_mis));
        chk({tag, ".wen"}, 64'(reg_wen_o), 64'(rw_in && !v.exp_mis));
        chk({tag, ".commit"}, 64'(commit_o), 64'd1);
        chk({tag, ".rd"}, 64'(rd_o), 64'(rd_i));
        chk({tag, ".pc"}, pc_o, pc_i);
        chk({tag, ".pre_pc"}, pre_pc_o, pre_pc_i);
        chk({tag, ".instr"}, 64'(instr_o), 64'(instr_i));
      end
    end
  endtask

  vec_t tbl[13];
  vec_t rv;

  initial begin
    // info, addr, rs2, rdata, delay, exp_wb, exp_wstrb, exp_wdata, exp_mis
    tbl[0]  = '{11'h004, 64'h1004, 64'h0, 64'h80000000_00000000, 2, 64'hFFFFFFFF_80000000, 8'h00, 64'h0, 1'b0};
    tbl[1]  = '{11'h080, 64'h2003, 64'hAB, 64'h0, 1, 64'h2003, 8'h08, 64'hABABABAB_ABABABAB, 1'b0};
    tbl[2]  = '{11'h002, 64'h3001, 64'h0, 64'h0, 0, 64'h3001, 8'h00, 64'h0, 1'b1};
    tbl[3]  = '{11'h008, 64'h4000, 64'h0, 64'h11223344_55667788, 0, 64'h11223344_55667788, 8'h00, 64'h0, 1'b0};
    tbl[4]  = '{11'h000, 64'h55, 64'h0, 64'h0, 0, 64'h55, 8'h00, 64'h0, 1'b0};
    tbl[5]  = '{11'h010, 64'h5007, 64'h0, 64'hF0000000_00000000, 1, 64'hF0, 8'h00, 64'h0, 1'b0};
    tbl[6]  = '{11'h001, 64'h5007, 64'h0, 64'hF0000000_00000000, 3, 64'hFFFFFFFF_FFFFFFF0, 8'h00, 64'h0, 1'b0};
    tbl[7]  = '{11'h100, 64'h6006, 64'h1234, 64'h0, 0, 64'h6006, 8'hC0, 64'h12341234_12341234, 1'b0};
    tbl[8]  = '{11'h200, 64'h7004, 64'hDEADBEEF, 64'h0, 2, 64'h7004, 8'hF0, 64'hDEADBEEF_DEADBEEF, 1'b0};
    tbl[9]  = '{11'h400, 64'h8000, 64'h01234567_89ABCDEF, 64'h0, 1, 64'h8000, 8'hFF, 64'h01234567_89ABCDEF, 1'b0};
    tbl[10] = '{11'h003, 64'h99, 64'h0, 64'h0, 0, 64'h99, 8'h00, 64'h0, 1'b0};
    tbl[11] = '{11'h400, 64'h8004, 64'h5, 64'h0, 0, 64'h8004, 8'h00, 64'h0, 1'b1};
    tbl[12] = '{11'h020, 64'h9002, 64'h0, 64'h00000000_80010000, 1, 64'h8001, 8'h00, 64'h0, 1'b0};

    rst = 1'b1; info_i = '0; alu_i = '0; rs2_i = '0; rd_i = '0; reg_wen_i = 1'b0;
    commit_i = 1'b0; pre_pc_i = '0; pc_i = '0; instr_i = '0; ack_i = 1'b0; rdata_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset.req", 64'(req_o), 64'd0);
    chk("reset.stall", 64'(stall_o), 64'd0);
    chk("reset.commit", 64'(commit_o), 64'd0);

    for (int i = 0; i < 13; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // Reset while waiting on the bus, then an ack that arrives too late.
    @(posedge clk); #1;
    info_i = 11'h004; alu_i = 64'h1000; reg_wen_i = 1'b1; commit_i = 1'b1; ack_i = 1'b0;
    @(negedge clk);
    chk("rstwait.req0", 64'(req_o), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstwait.stall1", 64'(stall_o), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; info_i = '0; commit_i = 1'b0; reg_wen_i = 1'b0;
    ack_i = 1'b1; rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    chk("rstwait.req_late", 64'(req_o), 64'd0);
    chk("rstwait.stall_late", 64'(stall_o), 64'd0);
    chk("rstwait.commit_late", 64'(commit_o), 64'd0);
    @(posedge clk); #1;
    ack_i = 1'b0;
    @(negedge clk);
    chk("rstwait.req_idle", 64'(req_o), 64'd0);
    run_op(model(11'h040, 64'h1004, 64'h0, 64'hCAFEF00D_00000000, 1), "rstwait.after");

    for (int i = 0; i < 80; i++) begin
      int r, a, b, n;
      logic [10:0] inf;
      logic [63:0] ad;
      r = $urandom_range(0, 12);
      if (r <= 10) inf = 11'(1 << r);
      else if (r == 11) inf = '0;
      else begin
        a = $urandom_range(0, 10);
        b = (a + $urandom_range(1, 10)) % 11;
        inf = 11'((1 << a) | (1 << b));
      end
      ad = {$urandom, $urandom};
      n  = size_of(inf);
      if ($urandom_range(0, 3) != 0) ad = ad & ~64'(n - 1);
      rv = model(inf, ad, {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3));
      run_op(rv, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
